// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl: job sequencer in front of mvm_8_1_8_1.
//
// Collects one job (matrix A in row-major order, then vector x) from a
// valid/ready stream that may have bubbles. It replays the job to the MVM as a
// gap-free burst, pulses start, captures the K serialized results, and returns
// them on a valid/ready stream with backpressure.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   in_data/in_valid/in_ready  job word input stream
//   out_data/out_valid/
//   out_ready/out_last         result output stream, out_last marks y[K-1]
//   busy                       job in flight
//   err                        sticky MVM timeout flag
//   m_loadMatrix/m_loadVector/
//   m_start/m_data_in          registered drive to the MVM
//   m_done/m_data_out          MVM completion and serialized results
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_COLLECT_A | accept K*K matrix words into abuf
// S_COLLECT_X | accept K vector words into xbuf
// S_LOAD_A    | cnt 0: loadMatrix strobe, cnt 1..K*K: A words
// S_LOAD_X    | cnt 0: idle, 1: loadVector, 2..K+1: x words, K+2: idle
// S_START     | start strobe
// S_WAIT      | wait for m_done, timeout down-counter running
// S_CAPTURE   | store y[cnt] from m_data_out
// S_DRAIN     | present rbuf[cnt] on the output stream
module mvm_seq_ctrl #(
  parameter int K       = 8,
  parameter int b       = 8,
  parameter int TIMEOUT = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [b-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*b-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           busy,
  output logic           err,
  output logic           m_loadMatrix,
  output logic           m_loadVector,
  output logic           m_start,
  output logic [b-1:0]   m_data_in,
  input  logic           m_done,
  input  logic [2*b-1:0] m_data_out
);

  localparam int KK = K * K;
  localparam int CW = $clog2(KK + 1);
  localparam int AW = (KK > 1) ? $clog2(KK) : 1;
  localparam int XW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_TWO    = CW'(2);
  localparam logic [CW-1:0] C_K_M1   = CW'(K - 1);
  localparam logic [CW-1:0] C_K_P1   = CW'(K + 1);
  localparam logic [CW-1:0] C_LX_END = CW'(K + 2);
  localparam logic [CW-1:0] C_KK     = CW'(KK);
  localparam logic [CW-1:0] C_KK_M1  = CW'(KK - 1);
  // WAIT lasts TIMEOUT-1 cycles so err becomes visible TIMEOUT cycles after start.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_COLLECT_A, S_COLLECT_X, S_LOAD_A, S_LOAD_X,
    S_START, S_WAIT, S_CAPTURE, S_DRAIN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          err_n;
  logic          lm_n, lv_n, st_n;
  logic [b-1:0]  din_n;
  logic [AW-1:0] a_wr, a_rd;
  logic [XW-1:0] x_idx, x_rd;
  logic          in_xfer, out_xfer;

  logic [b-1:0]   abuf [KK];
  logic [b-1:0]   xbuf [K];
  logic [2*b-1:0] rbuf [K];

  assign in_ready  = !reset && (state == S_COLLECT_A || state == S_COLLECT_X);
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (state == S_DRAIN);
  assign out_xfer  = out_valid && out_ready;
  assign a_wr      = cnt[AW-1:0];
  assign x_idx     = cnt[XW-1:0];
  assign out_data  = out_valid ? rbuf[x_idx] : '0;
  assign out_last  = out_valid && (cnt == C_K_M1);
  assign busy      = !(state == S_COLLECT_A && cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tmr_n   = tmr;
    err_n   = err;
    case (state)
      S_COLLECT_A:
        if (in_xfer) begin
          if (cnt == C_KK_M1) begin
            state_n = S_COLLECT_X;
            cnt_n   = '0;
          end else cnt_n = cnt + C_ONE;
        end
      S_COLLECT_X:
        if (in_xfer) begin
          if (cnt == C_K_M1) begin
            state_n = S_LOAD_A;
            cnt_n   = '0;
          end else cnt_n = cnt + C_ONE;
        end
      S_LOAD_A:
        if (cnt == C_KK) begin
          state_n = S_LOAD_X;
          cnt_n   = '0;
        end else cnt_n = cnt + C_ONE;
      S_LOAD_X:
        if (cnt == C_LX_END) begin
          state_n = S_START;
          cnt_n   = '0;
        end else cnt_n = cnt + C_ONE;
      S_START: begin
        state_n = S_WAIT;
        tmr_n   = TMR_LOAD;
      end
      S_WAIT:
        // done wins over a timeout landing in the same cycle
        if (m_done) begin
          state_n = S_CAPTURE;
          cnt_n   = '0;
          tmr_n   = '0;
        end else if (tmr == '0) begin
          state_n = S_COLLECT_A;
          err_n   = 1'b1;
        end else tmr_n = tmr - TW'(1);
      S_CAPTURE:
        if (cnt == C_K_M1) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else cnt_n = cnt + C_ONE;
      S_DRAIN:
        if (out_xfer) begin
          if (cnt == C_K_M1) begin
            state_n = S_COLLECT_A;
            cnt_n   = '0;
          end else cnt_n = cnt + C_ONE;
        end
      default: state_n = S_COLLECT_A;
    endcase
  end

  // MVM drive is decoded from the next state so the strobes leave a register.
  always_comb begin
    lm_n  = 1'b0;
    lv_n  = 1'b0;
    st_n  = 1'b0;
    din_n = '0;
    a_rd  = AW'(cnt_n - C_ONE);
    x_rd  = XW'(cnt_n - C_TWO);
    case (state_n)
      S_LOAD_A:
        if (cnt_n == '0) lm_n = 1'b1;
        else din_n = abuf[a_rd];
      S_LOAD_X:
        if (cnt_n == C_ONE) lv_n = 1'b1;
        else if (cnt_n >= C_TWO && cnt_n <= C_K_P1) din_n = xbuf[x_rd];
      S_START: st_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_COLLECT_A;
      cnt          <= '0;
      tmr          <= '0;
      err          <= 1'b0;
      m_loadMatrix <= 1'b0;
      m_loadVector <= 1'b0;
      m_start      <= 1'b0;
      m_data_in    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      tmr          <= tmr_n;
      err          <= err_n;
      m_loadMatrix <= lm_n;
      m_loadVector <= lv_n;
      m_start      <= st_n;
      m_data_in    <= din_n;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && state == S_COLLECT_A) abuf[a_wr] <= in_data;
    if (in_xfer && state == S_COLLECT_X) xbuf[x_idx] <= in_data;
    if (state == S_CAPTURE) rbuf[x_idx] <= m_data_out;
  end

endmodule

// File: doc/mvm_seq_ctrl.md
Name: mvm_seq_ctrl

Overview:
Sequencer that sits directly upstream of mvm_8_1_8_1 and also collects its results. It accepts matrix and vector words on a valid/ready input stream, which may contain bubbles, and buffers one full job. It then replays the job to the MVM as the gap-free burst protocol the MVM requires, pulses start, and captures the K serialized results. Results are returned on a valid/ready output stream with backpressure.

Parameters:
K, 8, matrix dimension (KxK matrix, K-element vector)
b, 8, input word width; result width is 2*b
TIMEOUT, 256, max cycles from m_start to m_done before the job is aborted

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  b  signed matrix or vector word
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word
out_data  output  2*b  signed result y[i]
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts a word
out_last  output  1  high with y[K-1]
busy  output  1  job in flight (any state except COLLECT_A with count 0)
err  output  1  sticky timeout flag
m_loadMatrix  output  1  to MVM loadMatrix
m_loadVector  output  1  to MVM loadVector
m_start  output  1  to MVM start
m_data_in  output  b  to MVM data_in
m_done  input  1  from MVM done
m_data_out  input  2*b  from MVM data_out

Behaviour:
- Reset (async, active-high) sets state to COLLECT_A, zeroes all counters, and forces every output to 0, err included. in_ready reads 0 while reset is high and 1 in the first cycle after release. Buffer contents are don't-care.
- Handshakes: an input word transfers on in_valid&&in_ready; an output word transfers on out_valid&&out_ready. in_data is ignored when in_ready=0.
- Job input order: A row-major (K*K words), then x (K words).
- COLLECT_A: in_ready=1. Each transfer writes abuf[cnt] and increments cnt. The K*K-th transfer moves to COLLECT_X with cnt=0.
- COLLECT_X: in_ready=1. Each transfer writes xbuf[cnt]. The K-th transfer moves to LOAD. in_ready=0 in every other state.
- LOAD, cycle-exact, with c = the cycle of the last x transfer and K=8:
  - m_loadMatrix=1 at c+1.
  - m_data_in=A[0..63] on c+2..c+65, contiguous.
  - Idle at c+66.
  - m_loadVector=1 at c+67.
  - m_data_in=x[0..7] on c+68..c+75.
  - Idle at c+76.
  - m_start=1 at c+77, then go to WAIT.
  - General form: the start pulse is at c+K*K+K+5.
- All m_* strobes are single-cycle. m_data_in=0 outside data cycles. All m_* outputs are registered.
- WAIT: counts cycles from m_start. In the first cycle t0 with m_done=1, go to CAPTURE. The MVM presents y[i] on m_data_out in cycle t0+1+i, i=0..K-1; CAPTURE stores each into rbuf[i].
- Timeout: if the count reaches TIMEOUT with no m_done, set err=1 (sticky until reset), discard the job and go to COLLECT_A.
- DRAIN (entered after rbuf[K-1] is captured):
  - out_valid=1, out_data=rbuf[idx], out_last=(idx==K-1).
  - out_data and out_last stay stable while out_ready=0.
  - After the last transfer, go to COLLECT_A in the next cycle with out_valid=0.
- Arithmetic: none. Words pass through bit-exact, with signedness preserved; no width conversion.
- Counters are $clog2(K*K+1) bits and never wrap within a job. Each counter clears on its state exit.
- Simultaneous events: reset overrides everything. m_done arriving in the same cycle the timeout count hits TIMEOUT counts as done, with no error. m_done outside WAIT is ignored.
- Reset mid-operation, in any state: the job is abandoned, the outputs above are forced, and the next job after release must produce correct results.

Test Plan:
- Identity A (A[i][i]=1, else 0), x=1..8, in_valid always 1, out_ready always 1, real mvm_8_1_8_1 -> out_data 1,2,...,8 with out_last only on 8; m_start exactly 77 cycles after the last x transfer.
- A all -1 (0xFF), x=1..8 -> every y = -36 (0xFFDC); a second back-to-back job, A identity with x=-1..-8, -> y = -1..-8.
- in_valid toggled 1/0 each cycle during collection -> same results as the first scenario; m_data_in carries A for exactly 64 consecutive cycles with no gaps.
- out_ready held 0 for 5 cycles when out_valid first rises -> out_valid stays 1 and out_data stays y[0]=1; then all 8 results drain in order with no loss or duplication.
- reset pulsed during the LOAD A-burst (around word 30) -> all outputs 0 immediately; after release in_ready=1, and a fresh identity/x=1..8 job returns 1..8.
- m_done tied 0 with TIMEOUT=16 -> err=1 exactly 16 cycles after m_start, in_ready=1 the next cycle, out_valid never asserted; err stays 1 until reset.
